// File: rtl/jtag_er_pkg.sv
// Shared opcodes, FSM/chain-select encodings and status bit positions for jtag_er_cmd_ctrl.
// The optional ER1 parity bit is enabled by defining JTAG_CMD_PARITY_EN.
package jtag_er_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ER1  = 2'd1,
        SEL_ER2  = 2'd2
    } sel_e;

    localparam int STATUS_W      = 8;
    localparam int STAT_BUSY     = 0;
    localparam int STAT_RD_VALID = 1;
    localparam int STAT_OVERRUN  = 2;
    localparam int STAT_TIMEOUT  = 3;
    localparam int STAT_PAR_ERR  = 4;
    localparam int STAT_CNT_LSB  = 5;
    localparam int CNT_W         = 3;

endpackage

// File: rtl/jtag_er_shreg.sv
// Generic JTAG data-register: parallel capture, LSB-first right shift, registered serial out.
module jtag_er_shreg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] load_val_i,
    input  logic         sin_i,
    output logic [W-1:0] q_o,
    output logic         sout_o
);

    logic [W-1:0] sr_q;
    logic         sout_q;

    // NOTE: shift registers are plain flops, so they take the async reset like all other state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q   <= '0;
            sout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so sout_q samples the pre-shift LSB in the same edge.
            sout_q <= sr_q[0];
            if (load_i) begin
                sr_q <= load_val_i;
            end else if (shift_i) begin
                sr_q <= {sin_i, sr_q[W-1:1]};
            end
        end
    end

    assign q_o    = sr_q;
    assign sout_o = sout_q;

endmodule

// File: rtl/jtag_er_cmd_ctrl.sv
// ER1 command / ER2 status controller for the ECP5 JTAGG user chain, JTCK domain only.
// Define JTAG_CMD_PARITY_EN to append an even-parity MSB to the ER1 chain.
module jtag_er_cmd_ctrl
    import jtag_er_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              JTCK,
    input  logic              JRSTN,
    input  logic              JTDI,
    input  logic              JSHIFT,
    input  logic              JUPDATE,
    input  logic              JCE1,
    input  logic              JCE2,
    input  logic              JRTI1,
    output logic              JTDO1,
    output logic              JTDO2,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);

    localparam int DR_W = 2 + ADDR_W + DATA_W;
`ifdef JTAG_CMD_PARITY_EN
    localparam int ER1_W = DR_W + 1;
`else
    localparam int ER1_W = DR_W;
`endif
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e              state_q;
    sel_e                sel_q;
    logic                req_valid_q, req_we_q;
    logic [ADDR_W-1:0]   req_addr_q, last_addr_q;
    logic [DATA_W-1:0]   req_wdata_q, rd_data_q;
    logic                rd_valid_q, overrun_q, timeout_q, parity_err_q;
    logic [CNT_W-1:0]    cmd_cnt_q;
    logic [TMR_W-1:0]    tmr_q;

    logic [ER1_W-1:0]    er1_q, er1_cap;
    logic [DR_W-1:0]     er1_fields;
    logic [STATUS_W-1:0] er2_q, status;
    logic [1:0]          cmd_op;
    logic                cmd_rw, parity_ok, cap1, upd1, upd2;

    assign busy   = (state_q != ST_IDLE);
    assign cap1   = JCE1 && !JSHIFT;
    assign upd1   = JUPDATE && (sel_q == SEL_ER1);
    assign upd2   = JUPDATE && (sel_q == SEL_ER2);
    assign cmd_op = er1_q[DR_W-1 -: 2];

    assign er1_fields = {rd_valid_q, busy, last_addr_q, rd_data_q};
`ifdef JTAG_CMD_PARITY_EN
    assign er1_cap   = {^er1_fields, er1_fields};
    assign parity_ok = ~^er1_q;
`else
    assign er1_cap   = er1_fields;
    assign parity_ok = 1'b1;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cmd_rw = 1'b0;
        case (cmd_op)
            OP_WR, OP_RD:   cmd_rw = 1'b1;
            OP_NOP, OP_RSV: cmd_rw = 1'b0;
        endcase
    end

    always_comb begin
        status                              = '0;
        status[STAT_BUSY]                   = busy;
        status[STAT_RD_VALID]               = rd_valid_q;
        status[STAT_OVERRUN]                = overrun_q;
        status[STAT_TIMEOUT]                = timeout_q;
        status[STAT_PAR_ERR]                = parity_err_q;
        status[STAT_CNT_LSB +: CNT_W]       = cmd_cnt_q;
    end

    jtag_er_shreg #(.W(ER1_W)) u_er1 (
        .clk_i      (JTCK),
        .rst_ni     (JRSTN),
        .load_i     (cap1),
        .shift_i    (JCE1 && JSHIFT),
        .load_val_i (er1_cap),
        .sin_i      (JTDI),
        .q_o        (er1_q),
        .sout_o     (JTDO1)
    );

    jtag_er_shreg #(.W(STATUS_W)) u_er2 (
        .clk_i      (JTCK),
        .rst_ni     (JRSTN),
        .load_i     (JCE2 && !JSHIFT),
        .shift_i    (JCE2 && JSHIFT),
        .load_val_i (status),
        .sin_i      (JTDI),
        .q_o        (er2_q),
        .sout_o     (JTDO2)
    );

    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            state_q      <= ST_IDLE;
            sel_q        <= SEL_NONE;
            req_valid_q  <= 1'b0;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            last_addr_q  <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            parity_err_q <= 1'b0;
            cmd_cnt_q    <= '0;
            tmr_q        <= '0;
        end else begin
            if (JCE1)         sel_q <= SEL_ER1;
            else if (JCE2)    sel_q <= SEL_ER2;
            else if (JUPDATE) sel_q <= SEL_NONE;

            // Clears come first; any set later in this block overrides them.
            if (cap1) rd_valid_q <= 1'b0;
            if (upd2) begin
                overrun_q    <= overrun_q    & ~er2_q[STAT_OVERRUN];
                timeout_q    <= timeout_q    & ~er2_q[STAT_TIMEOUT];
                parity_err_q <= parity_err_q & ~er2_q[STAT_PAR_ERR];
            end

            case (state_q)
                ST_IDLE: begin
                    if (upd1 && cmd_rw && parity_ok) begin
                        req_we_q    <= (cmd_op == OP_WR);
                        req_addr_q  <= er1_q[DATA_W +: ADDR_W];
                        req_wdata_q <= er1_q[DATA_W-1:0];
                        req_valid_q <= 1'b1;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_valid_q && req_ready) begin
                        req_valid_q <= 1'b0;
                        if (req_we_q) begin
                            cmd_cnt_q <= cmd_cnt_q + 3'd1;
                            state_q   <= ST_IDLE;
                        end else begin
                            tmr_q   <= '0;
                            state_q <= ST_WAIT_RSP;
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_valid) begin
                        rd_data_q   <= rsp_rdata;
                        last_addr_q <= req_addr_q;
                        rd_valid_q  <= 1'b1;
                        cmd_cnt_q   <= cmd_cnt_q + 3'd1;
                        state_q     <= ST_IDLE;
                    end else if (TIMEOUT_CYC != 0 && tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (upd1 && cmd_rw) begin
                if (!parity_ok) parity_err_q <= 1'b1;
                else if (busy)  overrun_q    <= 1'b1;
            end
        end
    end

    assign req_valid = req_valid_q;
    assign req_we    = req_we_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;

    logic unused_bits;
    assign unused_bits = ^{JRTI1, er2_q[7:5], er2_q[1:0]};

endmodule
